sample_deframer: RTL and testbench
==================================

// Module: sample_deframer
// PURPOSE
//  Consumes the 12-bit sample stream leaving the CDC FIFO read side and recovers frame boundaries.
//  Hunts for a 4-word sync header, then forwards PAYLOAD_LEN payload words tagged with sof/eof.
//  Tracks lock across back-to-back frames. Sits in the tx_clk domain, directly downstream of the FIFO.
// PARAMETERS
//  DW          12       sample width
//  SYNC0..3    12'hACD, 12'hFFF, 12'hEBE, 12'hFDC   header words, in arrival order
//  PAYLOAD_LEN 1024     payload words per frame, >=2; counter width $clog2(PAYLOAD_LEN)
// PORTS
//  clk_i        in   1   tx-side clock; single clock domain
//  rst_n_i      in   1   asynchronous, active-low reset
//  data_i       in   DW  sample from the FIFO read port
//  valid_i      in   1   data_i is a new word this cycle
//  data_o       out  DW  payload word, registered
//  valid_o      out  1   data_o valid; payload words only, never header words
//  sof_o        out  1   with valid_o: first payload word of a frame
//  eof_o        out  1   with valid_o: last payload word of a frame
//  locked_o     out  1   header seen immediately after the previous frame's eof
//  sync_err_o   out  1   1-cycle pulse: lock lost
// BEHAVIOUR
//  Reset: state=HUNT, match index 0, payload count 0.
//   All outputs 0: data_o=0, valid_o, sof_o, eof_o, locked_o, sync_err_o.
//  Words are consumed only when valid_i=1. valid_i=0 holds all state; valid_o, sof_o, eof_o are 0 that cycle.
//  FSM states: HUNT (match index m=0..3), PAYLOAD.
//   HUNT, word==SYNC[m]: m<3 -> m+1; m==3 -> enter PAYLOAD with count=0.
//   HUNT, mismatch: m <= (word==SYNC0) ? 1 : 0. Header words are never output.
//   PAYLOAD: each valid word appears on data_o/valid_o 1 cycle later.
//    sof_o is set on count 0; eof_o is set on count PAYLOAD_LEN-1; then state returns to HUNT with m=0.
//    Payload is not searched for SYNC words.
//  Latency: input word at cycle N -> data_o/valid_o at cycle N+1.
//  Lock:
//   - A header completed with no non-matching valid word since the previous eof sets locked_o.
//     locked_o rises 1 cycle after the SYNC3 word.
//   - The first frame after reset never sets locked_o; locked_o first rises on the second back-to-back header.
//   - While locked_o=1, any mismatch in HUNT: locked_o<=0, sync_err_o pulses for 1 cycle, and the mismatch rule above applies.
//   - sync_err_o fires only on a 1->0 transition of locked_o.
//  Reset asserted mid-frame clears everything asynchronously. After release, the block hunts again and partial payload is discarded.
//  No backpressure: the downstream consumer must accept every valid_o word.
// CONFIGURATION
//  SAMPLE_DEFRAMER_STATS_EN defined: adds two outputs.
//   frame_cnt_o[15:0]: +1 per eof, wraps FFFF->0000.
//   lock_loss_cnt_o[7:0]: +1 per sync_err_o, saturates at FF.
//   Both counters reset to 0.
//  Not defined: these ports and counters do not exist. All other behaviour is identical.
// TESTING (PAYLOAD_LEN=16 in bench)
//  1 Reset, then ACD,FFF,EBE,FDC + 16 words ABC/FFF/DDD/CCC repeating
//    -> 16 valid_o words, sof on word0=ABC, eof on word15=CCC, locked_o=0.
//  2 Second header immediately after test 1
//    -> locked_o=1 one cycle after FDC; next frame outputs normally.
//  3 Partial headers ACD,FFF,ACD,FFF,EBE,FDC + payload
//    -> frame found; sof on the first payload word; no header words on data_o.
//  4 While locked, send 12'h123 in place of ACD
//    -> sync_err_o 1-cycle pulse, locked_o=0; next valid header resumes framing with locked_o=0.
//  5 valid_i toggled 1/0 throughout a frame
//    -> identical data/sof/eof sequence; valid_o=0 on gap cycles; latency stays 1.
//  6 Deassert rst_n_i at payload word 7, release, resend a full frame
//    -> outputs 0 during reset; next frame sof on its word0; STATS_EN frame_cnt_o=1.

Source files
------------

// File: rtl/sample_deframer.sv
// Frame recovery for the 12-bit sample stream: hunts for a 4-word sync header, then forwards tagged payload.
// Optional statistics counters are enabled with the SAMPLE_DEFRAMER_STATS_EN macro.
module sample_deframer #(
    parameter int              DW          = 12,
    parameter logic [DW-1:0]   SYNC0       = 12'hACD,
    parameter logic [DW-1:0]   SYNC1       = 12'hFFF,
    parameter logic [DW-1:0]   SYNC2       = 12'hEBE,
    parameter logic [DW-1:0]   SYNC3       = 12'hFDC,
    parameter int              PAYLOAD_LEN = 1024
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          sof_o,
    output logic          eof_o,
    output logic          locked_o,
`ifdef SAMPLE_DEFRAMER_STATS_EN
    output logic [15:0]   frame_cnt_o,
    output logic [7:0]    lock_loss_cnt_o,
`endif
    output logic          sync_err_o
);

    localparam int CW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_LEN - 1);
    localparam logic [3:0][DW-1:0] SYNC = {SYNC3, SYNC2, SYNC1, SYNC0};

    typedef enum logic {
        HUNT,
        PAYLOAD
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Set at eof, cleared by any non-matching hunt word: a header completed while set earns lock.
    logic          clean_q, clean_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic [DW-1:0] sync_word;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= HUNT;
            m_q      <= '0;
            cnt_q    <= '0;
            clean_q  <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        locked_d  = locked_q;
        err_d     = 1'b0;
        sync_word = SYNC[m_q];

        if (valid_i) begin
            unique case (state_q)
                HUNT: begin
                    if (data_i == sync_word) begin
                        if (m_q == 2'd3) begin
                            state_d  = PAYLOAD;
                            cnt_d    = '0;
                            m_d      = '0;
                            locked_d = clean_q;
                        end else begin
                            m_d = m_q + 2'd1;
                        end
                    end else begin
                        // A stray SYNC0 may itself start a fresh header.
                        m_d     = (data_i == SYNC0) ? 2'd1 : 2'd0;
                        clean_d = 1'b0;
                        if (locked_q) begin
                            locked_d = 1'b0;
                            err_d    = 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    data_d  = data_i;
                    valid_d = 1'b1;
                    sof_d   = (cnt_q == '0);
                    if (cnt_q == LAST_CNT) begin
                        eof_d   = 1'b1;
                        state_d = HUNT;
                        m_d     = '0;
                        cnt_d   = '0;
                        clean_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    m_d     = '0;
                end
            endcase
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign sof_o      = sof_q;
    assign eof_o      = eof_q;
    assign locked_o   = locked_q;
    assign sync_err_o = err_q;

`ifdef SAMPLE_DEFRAMER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  lock_loss_cnt_q;

    // Counters advance on the same edge that raises eof_o / sync_err_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_cnt_q     <= '0;
            lock_loss_cnt_q <= '0;
        end else begin
            if (eof_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (err_d && (lock_loss_cnt_q != 8'hFF)) begin
                lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
            end
        end
    end

    assign frame_cnt_o     = frame_cnt_q;
    assign lock_loss_cnt_o = lock_loss_cnt_q;
`endif

endmodule

// File: tb/tb_sample_deframer.sv
// Bench for sample_deframer: window-based reference model checked every cycle, plus directed literal checks.
module tb_sample_deframer;
    localparam int LEN = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] data_i;
    logic        valid_i;
    logic [11:0] data_o;
    logic        valid_o, sof_o, eof_o, locked_o, sync_err_o;
`ifdef SAMPLE_DEFRAMER_STATS_EN
    logic [15:0] frame_cnt_o;
    logic [7:0]  lock_loss_cnt_o;
`endif

    always #5 clk = ~clk;

    sample_deframer #(.PAYLOAD_LEN(LEN)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .data_i(data_i),
        .valid_i(valid_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .sof_o(sof_o),
        .eof_o(eof_o),
        .locked_o(locked_o),
`ifdef SAMPLE_DEFRAMER_STATS_EN
        .frame_cnt_o(frame_cnt_o),
        .lock_loss_cnt_o(lock_loss_cnt_o),
`endif
        .sync_err_o(sync_err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: header = last four hunt words equal the sync sequence;
    // lock = that header was the only thing seen since a previous eof.
    logic [11:0] sync_t [4] = '{12'hACD, 12'hFFF, 12'hEBE, 12'hFDC};
    logic [11:0] win [$];
    bit          in_pay, broken, seen_eof, mism;
    int          pcnt, hcnt;
    logic [11:0] e_data;
    bit          e_valid, e_sof, e_eof, e_locked, e_err;
    int          e_fcnt, e_lcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win.delete();
            in_pay = 0; broken = 0; seen_eof = 0; pcnt = 0; hcnt = 0;
            e_data = '0; e_valid = 0; e_sof = 0; e_eof = 0; e_locked = 0; e_err = 0;
            e_fcnt = 0; e_lcnt = 0;
        end else begin
            e_valid = 0; e_sof = 0; e_eof = 0; e_err = 0;
            if (valid_i) begin
                if (in_pay) begin
                    e_valid = 1;
                    e_data  = data_i;
                    e_sof   = (pcnt == 0);
                    e_eof   = (pcnt == LEN - 1);
                    pcnt++;
                    if (e_eof) begin
                        in_pay = 0; hcnt = 0; broken = 0; seen_eof = 1;
                        e_fcnt = (e_fcnt + 1) % 65536;
                    end
                end else begin
                    mism = (hcnt >= 4) ? 1'b1 : (data_i != sync_t[hcnt]);
                    if (mism && !broken) begin
                        broken = 1;
                        if (e_locked) begin
                            e_locked = 0;
                            e_err    = 1;
                            if (e_lcnt < 255) e_lcnt++;
                        end
                    end
                    hcnt++;
                    win.push_back(data_i);
                    if (win.size() > 4) void'(win.pop_front());
                    if (win.size() == 4 && win[0] == sync_t[0] && win[1] == sync_t[1] &&
                        win[2] == sync_t[2] && win[3] == sync_t[3]) begin
                        in_pay   = 1;
                        pcnt     = 0;
                        win.delete();
                        e_locked = seen_eof && !broken;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("valid_o", valid_o, e_valid);
        chk("sof_o", sof_o, e_sof);
        chk("eof_o", eof_o, e_eof);
        chk("locked_o", locked_o, e_locked);
        chk("sync_err_o", sync_err_o, e_err);
        if (e_valid) chk("data_o", data_o, e_data);
`ifdef SAMPLE_DEFRAMER_STATS_EN
        chk("frame_cnt_o", frame_cnt_o, e_fcnt);
        chk("lock_loss_cnt_o", lock_loss_cnt_o, e_lcnt);
`endif
    end

    // Observed-output tallies for the directed literal checks.
    int          n_valid = 0, n_sof = 0, n_eof = 0, n_err = 0;
    logic [11:0] sof_word = '0, eof_word = '0;
    always @(negedge clk) begin
        if (valid_o) n_valid++;
        if (valid_o && sof_o) begin n_sof++; sof_word = data_o; end
        if (valid_o && eof_o) begin n_eof++; eof_word = data_o; end
        if (sync_err_o) n_err++;
        if (valid_o || sof_o || eof_o || locked_o || sync_err_o)
            $display("t=%0t data_o=%h valid=%0b sof=%0b eof=%0b locked=%0b err=%0b",
                     $time, data_o, valid_o, sof_o, eof_o, locked_o, sync_err_o);
    end

    function automatic logic [11:0] pat(input int i);
        case (i % 4)
            0: pat = 12'hABC;
            1: pat = 12'hFFF;
            2: pat = 12'hDDD;
            default: pat = 12'hCCC;
        endcase
    endfunction

    task automatic w(input logic [11:0] d, input logic v);
        data_i  = d;
        valid_i = v;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) w(12'h5A5, 1'b0);
    endtask

    task automatic hdr();
        for (int i = 0; i < 4; i++) w(sync_t[i], 1'b1);
    endtask

    task automatic pay(input bit gaps);
        for (int i = 0; i < LEN; i++) begin
            w(pat(i), 1'b1);
            if (gaps) w(12'h5A5, 1'b0);
        end
    endtask

    int v0, s0, e0, r0;

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_o", data_o, 0);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_locked_o", locked_o, 0);
        chk("rst_sync_err_o", sync_err_o, 0);
        rst_n = 1'b1;
        idle(2);

        // 1: first frame after reset
        v0 = n_valid; s0 = n_sof; e0 = n_eof; r0 = n_err;
        hdr();
        chk("t1_lock_after_hdr", locked_o, 0);
        pay(0); idle(1);
        chk("t1_nvalid", n_valid - v0, 16);
        chk("t1_nsof", n_sof - s0, 1);
        chk("t1_sof_word", sof_word, 12'hABC);
        chk("t1_eof_word", eof_word, 12'hCCC);
        chk("t1_locked", locked_o, 0);

        // 2: back-to-back header earns lock
        hdr();
        chk("t2_locked", locked_o, 1);
        chk("t2_model_locked", e_locked, 1);
        pay(0); idle(1);
        chk("t2_locked_hold", locked_o, 1);

        // 4: corrupt header while locked
        w(12'h123, 1'b1);
        chk("t4_err_pulse", sync_err_o, 1);
        chk("t4_unlocked", locked_o, 0);
        w(12'hFFF, 1'b1);
        chk("t4_err_once", sync_err_o, 0);
        w(12'hEBE, 1'b1); w(12'hFDC, 1'b1);
        v0 = n_valid;
        hdr(); pay(0); idle(1);
        chk("t4_nvalid", n_valid - v0, 16);
        chk("t4_locked", locked_o, 0);
        chk("t4_nerr", n_err - r0, 1);

        // 3: partial headers
        v0 = n_valid; s0 = n_sof;
        w(12'hACD, 1'b1); w(12'hFFF, 1'b1);
        w(12'hACD, 1'b1); w(12'hFFF, 1'b1); w(12'hEBE, 1'b1); w(12'hFDC, 1'b1);
        pay(0); idle(1);
        chk("t3_nvalid", n_valid - v0, 16);
        chk("t3_nsof", n_sof - s0, 1);
        chk("t3_sof_word", sof_word, 12'hABC);
        chk("t3_locked", locked_o, 0);

        // 5: gapped input
        v0 = n_valid; e0 = n_eof;
        for (int i = 0; i < 4; i++) begin w(sync_t[i], 1'b1); w(12'hACD, 1'b0); end
        chk("t5_locked", locked_o, 1);
        pay(1); idle(1);
        chk("t5_nvalid", n_valid - v0, 16);
        chk("t5_neof", n_eof - e0, 1);
        chk("t5_eof_word", eof_word, 12'hCCC);

        // 6: reset mid-frame
        hdr();
        for (int i = 0; i < 7; i++) w(pat(i), 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", valid_o, 0);
        chk("t6_rst_locked", locked_o, 0);
        chk("t6_rst_data", data_o, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        v0 = n_valid; s0 = n_sof;
        hdr(); pay(0); idle(1);
        chk("t6_nvalid", n_valid - v0, 16);
        chk("t6_nsof", n_sof - s0, 1);
        chk("t6_sof_word", sof_word, 12'hABC);
        chk("t6_locked", locked_o, 0);
`ifdef SAMPLE_DEFRAMER_STATS_EN
        chk("t6_frame_cnt", frame_cnt_o, 1);
        chk("t6_lock_loss_cnt", lock_loss_cnt_o, 0);
`endif
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
